// File: rtl/iob_axis_upsizer_pkg.sv
// iob_axis_upsizer_pkg: width derivation, parameter legality checks and tkeep lane mask
package iob_axis_upsizer_pkg;
  localparam int KEEP_MAX_W = 128;
  function automatic int ratio_of(input int in_w, input int out_w);
    return out_w / in_w;
  endfunction
  function automatic int cnt_w_of(input int in_w, input int out_w);
    return $clog2(out_w / in_w);
  endfunction
  function automatic bit is_pow2(input int v);
    return v > 0 && (v & (v - 1)) == 0;
  endfunction
  function automatic bit params_ok(input int in_w, input int out_w);
    return is_pow2(in_w) && is_pow2(out_w) && out_w / in_w >= 2;
  endfunction
  function automatic logic [KEEP_MAX_W-1:0] lane_keep(input int k, input int in_w);
    logic [KEEP_MAX_W-1:0] ones;
    ones = '1;
    return ~(ones << ((k + 1) * in_w / 8));
  endfunction
endpackage

// File: rtl/iob_axis_upsizer_out_reg.sv
// iob_axis_upsizer_out_reg: registered output word with load-over-consume priority (m_tkeep_o under IOB_AXIS_UPSIZER_TKEEP_EN)
module iob_axis_upsizer_out_reg #(
  parameter int OUT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [OUT_W-1:0] data_i,
  input  logic             last_i,
`ifdef IOB_AXIS_UPSIZER_TKEEP_EN
  input  logic [OUT_W/8-1:0] keep_i,
  output logic [OUT_W/8-1:0] m_tkeep_o,
`endif
  input  logic             m_tready_i,
  output logic             out_free_o,
  output logic [OUT_W-1:0] m_tdata_o,
  output logic             m_tvalid_o,
  output logic             m_tlast_o
);
  logic             valid_q, valid_d, last_q, last_d;
  logic [OUT_W-1:0] data_q, data_d;
`ifdef IOB_AXIS_UPSIZER_TKEEP_EN
  logic [OUT_W/8-1:0] keep_q, keep_d;
  always_comb keep_d = load_i ? keep_i : keep_q;
  always_ff @(posedge clk_i) keep_q <= rst_i ? '0 : keep_d;
  assign m_tkeep_o = keep_q;
`endif
  always_comb begin
    out_free_o = !valid_q || m_tready_i;
    valid_d = load_i || (valid_q && !m_tready_i);
    data_d = load_i ? data_i : data_q;
    last_d = load_i ? last_i : last_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q <= '0;
      last_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q <= data_d;
      last_q <= last_d;
    end
  end
  assign m_tdata_o = data_q;
  assign m_tvalid_o = valid_q;
  assign m_tlast_o = last_q;
endmodule

// File: rtl/iob_axis_upsizer.sv
// iob_axis_upsizer: little-endian IN_W->OUT_W AXIS packer with tlast flush; IOB_AXIS_UPSIZER_TKEEP_EN adds m_tkeep_o
module iob_axis_upsizer
  import iob_axis_upsizer_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IN_W-1:0]  s_tdata_i,
  input  logic             s_tvalid_i,
  input  logic             s_tlast_i,
  output logic             s_tready_o,
  output logic [OUT_W-1:0] m_tdata_o,
  output logic             m_tvalid_o,
  output logic             m_tlast_o,
`ifdef IOB_AXIS_UPSIZER_TKEEP_EN
  output logic [OUT_W/8-1:0] m_tkeep_o,
`endif
  input  logic             m_tready_i
);
  localparam int RATIO = ratio_of(IN_W, OUT_W);
  localparam int CNT_W = cnt_w_of(IN_W, OUT_W);
  if (!params_ok(IN_W, OUT_W)) begin : g_bad_params
    $error("iob_axis_upsizer: IN_W/OUT_W must be powers of 2 with OUT_W/IN_W >= 2");
  end
  logic             out_free, accept, done;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] acc_q, acc_d, word;
  always_comb begin
    accept = s_tvalid_i && out_free;
    done = accept && (cnt_q == CNT_W'(RATIO - 1) || s_tlast_i);
    word = acc_q | (OUT_W'(s_tdata_i) << (cnt_q * IN_W));
    cnt_d = done ? '0 : accept ? cnt_q + 1'b1 : cnt_q;
    acc_d = done ? '0 : accept ? word : acc_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end
`ifdef IOB_AXIS_UPSIZER_TKEEP_EN
  if (IN_W < 8) begin : g_bad_keep
    $error("iob_axis_upsizer: tkeep needs IN_W >= 8");
  end
  logic [OUT_W/8-1:0] keep;
  always_comb keep = (OUT_W/8)'(lane_keep(int'(cnt_q), IN_W));
`endif
  iob_axis_upsizer_out_reg #(.OUT_W(OUT_W)) u_out_reg (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (done),
    .data_i     (word),
    .last_i     (s_tlast_i),
`ifdef IOB_AXIS_UPSIZER_TKEEP_EN
    .keep_i     (keep),
    .m_tkeep_o  (m_tkeep_o),
`endif
    .m_tready_i (m_tready_i),
    .out_free_o (out_free),
    .m_tdata_o  (m_tdata_o),
    .m_tvalid_o (m_tvalid_o),
    .m_tlast_o  (m_tlast_o)
  );
  assign s_tready_o = out_free;
endmodule
